regfile_wb_arbiter: RTL and testbench

Shares the single register-file write port (RegWr/RW/BusW) between two writeback requesters: A (execute) and B (memory/late load). Requesters use valid/ready handshakes and are granted round-robin. The accepted write is registered onto the write port. A pending-write scoreboard tells decode whether a source register has an outstanding write, and blocks a second reservation of the same destination register (WAW).

---
 rtl/regfile_wb_arbiter_pkg.sv | 13 +
 rtl/regfile_wb_arbiter_wb_scoreboard.sv | 52 +++++
 rtl/regfile_wb_arbiter.sv | 85 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and grant encoding for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

   localparam int DATA_WIDTH_DEF = 64;
   localparam int ADDR_WIDTH_DEF = 5;
   localparam int ZERO_REG_DEF   = 31;

   typedef enum logic {
      GNT_A = 1'b0,
      GNT_B = 1'b1
   } grant_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Pending-write scoreboard: tracks reserved destinations and reports RAW/WAW hazards to decode.
module wb_scoreboard
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int ZERO_REG   = ZERO_REG_DEF
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Reserve,
   input  logic [ADDR_WIDTH-1:0] ReserveAddr,
   input  logic                  ClrEn,
   input  logic [ADDR_WIDTH-1:0] ClrAddr,
   input  logic                  RegWr,
   input  logic [ADDR_WIDTH-1:0] RW,
   input  logic [ADDR_WIDTH-1:0] RA,
   input  logic [ADDR_WIDTH-1:0] RB,
   output logic                  ReserveReady,
   output logic                  BusyA,
   output logic                  BusyB
);

   localparam int NumRegs = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZeroAddr = ADDR_WIDTH'(ZERO_REG);

   logic [NumRegs-1:0] pending;
   logic [NumRegs-1:0] pendingNext;

   // Gated on the registered bits, so a same-cycle clear still stalls a reservation once.
   assign ReserveReady = !Reset && ((ReserveAddr == ZeroAddr) || !pending[ReserveAddr]);

   always_comb begin
      pendingNext = pending;
      if (ClrEn)
         pendingNext[ClrAddr] = 1'b0;
      if (Reserve && ReserveReady)
         pendingNext[ReserveAddr] = 1'b1;
      pendingNext[ZeroAddr] = 1'b0;
   end

   always_ff @(posedge Clk) begin
      if (Reset)
         pending <= '0;
      else
         pending <= pendingNext;
   end

   // The in-flight term covers the gap between the clear and the negedge register-file write.
   assign BusyA = (RA != ZeroAddr) && (pending[RA] || (RegWr && (RW == RA)));
   assign BusyB = (RB != ZeroAddr) && (pending[RB] || (RegWr && (RW == RB)));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between execute (A) and late-load (B).
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int ZERO_REG   = ZERO_REG_DEF
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  ReqAValid,
   output logic                  ReqAReady,
   input  logic [ADDR_WIDTH-1:0] ReqAAddr,
   input  logic [DATA_WIDTH-1:0] ReqAData,
   input  logic                  ReqBValid,
   output logic                  ReqBReady,
   input  logic [ADDR_WIDTH-1:0] ReqBAddr,
   input  logic [DATA_WIDTH-1:0] ReqBData,
   input  logic                  Reserve,
   input  logic [ADDR_WIDTH-1:0] ReserveAddr,
   output logic                  ReserveReady,
   input  logic [ADDR_WIDTH-1:0] RA,
   input  logic [ADDR_WIDTH-1:0] RB,
   output logic                  BusyA,
   output logic                  BusyB,
   output logic                  RegWr,
   output logic [ADDR_WIDTH-1:0] RW,
   output logic [DATA_WIDTH-1:0] BusW
);

   localparam logic [ADDR_WIDTH-1:0] ZeroAddr = ADDR_WIDTH'(ZERO_REG);

   grant_e                lastGrant;
   logic                  grantA;
   logic                  grantB;
   logic                  handshake;
   logic [ADDR_WIDTH-1:0] selAddr;
   logic [DATA_WIDTH-1:0] selData;

   // A wins a tie only when B held the previous grant.
   assign grantA    = !Reset && ReqAValid && (!ReqBValid || (lastGrant == GNT_B));
   assign grantB    = !Reset && ReqBValid && !grantA;
   assign handshake = grantA || grantB;
   assign ReqAReady = grantA;
   assign ReqBReady = grantB;
   assign selAddr   = grantA ? ReqAAddr : ReqBAddr;
   assign selData   = grantA ? ReqAData : ReqBData;

   // Write-port stage: RW/BusW settle at the posedge so the negedge capture sees stable data.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         RegWr     <= 1'b0;
         RW        <= '0;
         BusW      <= '0;
         lastGrant <= GNT_B;
      end else if (handshake) begin
         RegWr     <= (selAddr != ZeroAddr);
         RW        <= selAddr;
         BusW      <= selData;
         lastGrant <= grantA ? GNT_A : GNT_B;
      end else begin
         RegWr     <= 1'b0;
      end
   end

   wb_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG)
   ) uScoreboard (
      .Clk          (Clk),
      .Reset        (Reset),
      .Reserve      (Reserve),
      .ReserveAddr  (ReserveAddr),
      .ClrEn        (handshake),
      .ClrAddr      (selAddr),
      .RegWr        (RegWr),
      .RW           (RW),
      .RA           (RA),
      .RB           (RB),
      .ReserveReady (ReserveReady),
      .BusyA        (BusyA),
      .BusyB        (BusyB)
   );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        ReqAValid, ReqAReady;
   logic [4:0]  ReqAAddr;
   logic [63:0] ReqAData;
   logic        ReqBValid, ReqBReady;
   logic [4:0]  ReqBAddr;
   logic [63:0] ReqBData;
   logic        Reserve, ReserveReady;
   logic [4:0]  ReserveAddr;
   logic [4:0]  RA, RB;
   logic        BusyA, BusyB;
   logic        RegWr;
   logic [4:0]  RW;
   logic [63:0] BusW;

   int checks = 0;
   int errors = 0;

   regfile_wb_arbiter dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .ReqAValid    (ReqAValid),
      .ReqAReady    (ReqAReady),
      .ReqAAddr     (ReqAAddr),
      .ReqAData     (ReqAData),
      .ReqBValid    (ReqBValid),
      .ReqBReady    (ReqBReady),
      .ReqBAddr     (ReqBAddr),
      .ReqBData     (ReqBData),
      .Reserve      (Reserve),
      .ReserveAddr  (ReserveAddr),
      .ReserveReady (ReserveReady),
      .RA           (RA),
      .RB           (RB),
      .BusyA        (BusyA),
      .BusyB        (BusyB),
      .RegWr        (RegWr),
      .RW           (RW),
      .BusW         (BusW)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and land 1 time unit after the rising edge.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset = 1'b1;
      ReqAValid = 1'b1; ReqAAddr = 5'd3; ReqAData = 64'hAAAA;
      ReqBValid = 1'b1; ReqBAddr = 5'd4; ReqBData = 64'hBBBB;
      Reserve = 1'b1; ReserveAddr = 5'd5;
      RA = 5'd5; RB = 5'd3;

      tick();
      tick();
      chk("rst_readyA", ReqAReady, 1'b0);
      chk("rst_readyB", ReqBReady, 1'b0);
      chk("rst_resReady", ReserveReady, 1'b0);
      chk("rst_regwr", RegWr, 1'b0);
      chk("rst_rw", RW, 5'd0);
      chk("rst_busw", BusW, 64'd0);
      chk("rst_busyA", BusyA, 1'b0);
      chk("rst_busyB", BusyB, 1'b0);

      // Both valid continuously: A first, then alternate.
      Reset = 1'b0;
      Reserve = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("rr_readyA", ReqAReady, (i % 2 == 0));
         chk("rr_readyB", ReqBReady, (i % 2 == 1));
         tick();
         chk("rr_regwr", RegWr, 1'b1);
         chk("rr_rw", RW, (i % 2 == 0) ? 5'd3 : 5'd4);
         chk("rr_busw", BusW, (i % 2 == 0) ? 64'hAAAA : 64'hBBBB);
      end
      ReqAValid = 1'b0;
      ReqBValid = 1'b0;
      tick();
      chk("idle_regwr", RegWr, 1'b0);
      chk("idle_rw_hold", RW, 5'd4);
      chk("idle_busw_hold", BusW, 64'hBBBB);

      // Reserve R5, then B writes it.
      Reserve = 1'b1; ReserveAddr = 5'd5; RA = 5'd5;
      #1;
      chk("res5_ready", ReserveReady, 1'b1);
      chk("res5_busy_before", BusyA, 1'b0);
      tick();
      chk("res5_blocked", ReserveReady, 1'b0);
      chk("res5_busyA", BusyA, 1'b1);
      Reserve = 1'b0;
      ReqBValid = 1'b1; ReqBAddr = 5'd5; ReqBData = 64'h55;
      #1;
      chk("wb5_readyB", ReqBReady, 1'b1);
      chk("wb5_readyA", ReqAReady, 1'b0);
      tick();
      ReqBValid = 1'b0;
      #1;
      chk("wb5_regwr", RegWr, 1'b1);
      chk("wb5_rw", RW, 5'd5);
      chk("wb5_busw", BusW, 64'h55);
      chk("wb5_busy_inflight", BusyA, 1'b1);
      chk("wb5_res_ready", ReserveReady, 1'b1);
      tick();
      chk("wb5_regwr_off", RegWr, 1'b0);
      chk("wb5_busy_off", BusyA, 1'b0);

      // Zero register write is accepted and dropped; reserving it is a no-op.
      ReqAValid = 1'b1; ReqAAddr = 5'd31; ReqAData = 64'hFFFF;
      Reserve = 1'b1; ReserveAddr = 5'd31; RA = 5'd31;
      #1;
      chk("z_readyA", ReqAReady, 1'b1);
      chk("z_resReady", ReserveReady, 1'b1);
      tick();
      ReqAValid = 1'b0;
      #1;
      chk("z_regwr", RegWr, 1'b0);
      chk("z_rw", RW, 5'd31);
      chk("z_busw", BusW, 64'hFFFF);
      chk("z_busyA", BusyA, 1'b0);
      chk("z_resReady_after", ReserveReady, 1'b1);
      Reserve = 1'b0;
      tick();
      chk("z_busyA_later", BusyA, 1'b0);

      // Clear and reserve of R7 in the same cycle: reservation stalls one cycle.
      Reserve = 1'b1; ReserveAddr = 5'd7; RA = 5'd7; RB = 5'd7;
      tick();
      chk("r7_pending", BusyA, 1'b1);
      ReqAValid = 1'b1; ReqAAddr = 5'd7; ReqAData = 64'h77;
      #1;
      chk("r7_readyA", ReqAReady, 1'b1);
      chk("r7_res_stall", ReserveReady, 1'b0);
      tick();
      ReqAValid = 1'b0;
      #1;
      chk("r7_regwr", RegWr, 1'b1);
      chk("r7_res_retry_ready", ReserveReady, 1'b1);
      chk("r7_busy_inflight", BusyA, 1'b1);
      tick();
      Reserve = 1'b0;
      #1;
      chk("r7_regwr_off", RegWr, 1'b0);
      chk("r7_pending_again", BusyA, 1'b1);
      chk("r7_busyB", BusyB, 1'b1);

      // Grant R9 (plus reservation) then reset on the next edge.
      ReqAValid = 1'b1; ReqAAddr = 5'd9; ReqAData = 64'h99;
      Reserve = 1'b1; ReserveAddr = 5'd9; RA = 5'd9;
      #1;
      chk("r9_readyA", ReqAReady, 1'b1);
      tick();
      chk("r9_regwr", RegWr, 1'b1);
      chk("r9_rw", RW, 5'd9);
      chk("r9_busyA", BusyA, 1'b1);
      Reset = 1'b1;
      #1;
      chk("r9_rst_readyA", ReqAReady, 1'b0);
      chk("r9_rst_resReady", ReserveReady, 1'b0);
      tick();
      chk("r9_rst_regwr", RegWr, 1'b0);
      chk("r9_rst_rw", RW, 5'd0);
      chk("r9_rst_busyA", BusyA, 1'b0);
      chk("r9_rst_busyB", BusyB, 1'b0);
      Reset = 1'b0;
      ReqAValid = 1'b0;
      Reserve = 1'b0;
      tick();
      chk("post_rst_regwr", RegWr, 1'b0);
      chk("post_rst_busyA", BusyA, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
